// File: rtl/ttt_board_ctrl_if.sv
// Board controller bus: frame timing and buttons in, packed board and game status out.
// TTT_UNDO_EN adds the undo request line.
interface ttt_board_ctrl_if #(
    parameter int N  = 3,
    parameter int CW = 4
);
    logic                vnotactive;
    logic [N*N-1:0]      but_n;
    logic                clear;
`ifdef TTT_UNDO_EN
    logic                undo;
`endif
    logic [2*N*N-1:0]    board;
    logic                player;
    logic [CW-1:0]       move_cnt;
    logic [1:0]          winner;
    logic                game_over;
    logic                draw;

    modport master (
        output vnotactive, but_n, clear,
`ifdef TTT_UNDO_EN
        output undo,
`endif
        input  board, player, move_cnt, winner, game_over, draw
    );

    modport slave (
        input  vnotactive, but_n, clear,
`ifdef TTT_UNDO_EN
        input  undo,
`endif
        output board, player, move_cnt, winner, game_over, draw
    );
endinterface

// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl: N x N two-player board/turn controller, at most one move per video frame.
// Optional single-level undo of the last move when compiled with TTT_UNDO_EN.
module ttt_board_ctrl #(
    parameter int N  = 3,
    parameter int CW = 4
) (
    input  logic             CLK,
    input  logic             RST,
    ttt_board_ctrl_if.slave  bus
);
    localparam int NC = N * N;
    localparam int IW = $clog2(NC);

    typedef enum logic [1:0] {WAIT_BLANK, SAMPLE, CHECK, WAIT_ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [2*NC-1:0] board_q, board_d;
    logic            player_q, player_d;
    logic [CW-1:0]   move_cnt_q, move_cnt_d;
    logic [1:0]      winner_q, winner_d;
    logic            game_over_q, game_over_d;
    logic            draw_q, draw_d;
    logic [NC-1:0]   prev_press_q, prev_press_d;
`ifdef TTT_UNDO_EN
    logic [IW-1:0]   last_idx_q, last_idx_d;
    logic            undo_valid_q, undo_valid_d;
    logic            prev_undo_q, prev_undo_d;
`endif

    logic [NC-1:0]   press;
    logic [NC-1:0]   new_press;
    logic [IW-1:0]   new_idx;
    logic            cell_empty;
    logic [1:0]      win_code;

    // Owner code of the line starting at cell 'start' and stepping by 'step', or 00.
    function automatic logic [1:0] line_code(input logic [2*NC-1:0] b, input int start,
                                             input int step);
        logic [1:0] first;
        logic       same;
        first = b[2*start +: 2];
        same  = (first != 2'b00);
        for (int k = 1; k < N; k++)
            if (b[2*(start + k*step) +: 2] != first) same = 1'b0;
        return same ? first : 2'b00;
    endfunction

    always_comb begin
        press     = ~bus.but_n;
        new_press = press & ~prev_press_q;
        new_idx   = '0;
        for (int i = 0; i < NC; i++)
            if (new_press[i]) new_idx = IW'(i);
        cell_empty = (board_q[2*new_idx +: 2] == 2'b00);
    end

    always_comb begin
        win_code = 2'b00;
        for (int k = 0; k < N; k++) begin
            if (win_code == 2'b00) win_code = line_code(board_q, k*N, 1);
            if (win_code == 2'b00) win_code = line_code(board_q, k, N);
        end
        if (win_code == 2'b00) win_code = line_code(board_q, 0, N + 1);
        if (win_code == 2'b00) win_code = line_code(board_q, N - 1, N - 1);
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        player_d     = player_q;
        move_cnt_d   = move_cnt_q;
        winner_d     = winner_q;
        game_over_d  = game_over_q;
        draw_d       = draw_q;
        prev_press_d = prev_press_q;
`ifdef TTT_UNDO_EN
        last_idx_d   = last_idx_q;
        undo_valid_d = undo_valid_q;
        prev_undo_d  = prev_undo_q;
`endif
        if (bus.clear) begin
            // Buttons still held across a new game must not become a move.
            board_d      = '0;
            player_d     = 1'b0;
            move_cnt_d   = '0;
            winner_d     = 2'b00;
            game_over_d  = 1'b0;
            draw_d       = 1'b0;
            prev_press_d = press;
            state_d      = WAIT_ACTIVE;
`ifdef TTT_UNDO_EN
            undo_valid_d = 1'b0;
            prev_undo_d  = bus.undo;
`endif
        end else begin
            case (state_q)
                WAIT_BLANK: if (bus.vnotactive) state_d = SAMPLE;
                SAMPLE: begin
                    if (!game_over_q && $onehot(new_press) && cell_empty) begin
                        board_d[2*new_idx +: 2] = player_q ? 2'b10 : 2'b01;
                        player_d   = ~player_q;
                        move_cnt_d = move_cnt_q + CW'(1);
`ifdef TTT_UNDO_EN
                        last_idx_d   = new_idx;
                        undo_valid_d = 1'b1;
`endif
                    end
`ifdef TTT_UNDO_EN
                    else if (new_press == '0 && bus.undo && !prev_undo_q &&
                             undo_valid_q && move_cnt_q != '0) begin
                        board_d[2*last_idx_q +: 2] = 2'b00;
                        player_d     = ~player_q;
                        move_cnt_d   = move_cnt_q - CW'(1);
                        winner_d     = 2'b00;
                        draw_d       = 1'b0;
                        game_over_d  = 1'b0;
                        undo_valid_d = 1'b0;
                    end
                    prev_undo_d = bus.undo;
`endif
                    prev_press_d = press;
                    state_d      = CHECK;
                end
                CHECK: begin
                    if (win_code != 2'b00) begin
                        winner_d    = win_code;
                        game_over_d = 1'b1;
                    end else if (move_cnt_q == CW'(NC)) begin
                        draw_d      = 1'b1;
                        game_over_d = 1'b1;
                    end
                    state_d = WAIT_ACTIVE;
                end
                WAIT_ACTIVE: if (!bus.vnotactive) state_d = WAIT_BLANK;
                default:     state_d = WAIT_BLANK;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= WAIT_BLANK;
            board_q      <= '0;
            player_q     <= 1'b0;
            move_cnt_q   <= '0;
            winner_q     <= 2'b00;
            game_over_q  <= 1'b0;
            draw_q       <= 1'b0;
            prev_press_q <= '0;
`ifdef TTT_UNDO_EN
            last_idx_q   <= '0;
            undo_valid_q <= 1'b0;
            prev_undo_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            player_q     <= player_d;
            move_cnt_q   <= move_cnt_d;
            winner_q     <= winner_d;
            game_over_q  <= game_over_d;
            draw_q       <= draw_d;
            prev_press_q <= prev_press_d;
`ifdef TTT_UNDO_EN
            last_idx_q   <= last_idx_d;
            undo_valid_q <= undo_valid_d;
            prev_undo_q  <= prev_undo_d;
`endif
        end
    end

    assign bus.board     = board_q;
    assign bus.player    = player_q;
    assign bus.move_cnt  = move_cnt_q;
    assign bus.winner    = winner_q;
    assign bus.game_over = game_over_q;
    assign bus.draw      = draw_q;
endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Bench for ttt_board_ctrl (N=3): directed game scenarios plus random frames against a
// cell-array game model. Undo scenarios are included when TTT_UNDO_EN is defined.
module tb_ttt_board_ctrl;
    localparam int N  = 3;
    localparam int CW = 4;
    localparam int NC = N * N;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk, n_fail;

    int            m_cell [NC];
    int            m_player, m_moves, m_winner, m_over, m_draw, m_last, m_uv;
    logic [NC-1:0] m_prev;
    logic          m_pu;
    logic          undo_lvl;

    ttt_board_ctrl_if #(.N(N), .CW(CW)) bus ();

    ttt_board_ctrl #(.N(N), .CW(CW)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*NC-1:0] exp_board();
        logic [2*NC-1:0] b;
        b = '0;
        for (int i = 0; i < NC; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_cell[i] = 0;
        m_player = 0; m_moves = 0; m_winner = 0; m_over = 0; m_draw = 0;
        m_last = 0; m_uv = 0; m_prev = '0; m_pu = 1'b0;
    endtask

    task automatic model_sample(input logic [NC-1:0] press, input logic und);
        int cnt, idx;
        cnt = 0; idx = 0;
        for (int i = 0; i < NC; i++)
            if (press[i] && !m_prev[i]) begin cnt++; idx = i; end
        if (m_over == 0 && cnt == 1 && m_cell[idx] == 0) begin
            m_cell[idx] = m_player + 1;
            m_player = 1 - m_player;
            m_moves++;
            m_last = idx;
            m_uv = 1;
        end
`ifdef TTT_UNDO_EN
        else if (cnt == 0 && und && !m_pu && m_uv == 1 && m_moves > 0) begin
            m_cell[m_last] = 0;
            m_player = 1 - m_player;
            m_moves--;
            m_winner = 0; m_draw = 0; m_over = 0; m_uv = 0;
        end
`endif
        m_prev = press;
        m_pu = und;
    endtask

    // Scan every row, column and both diagonals in (row, col) coordinates.
    task automatic model_check();
        int w, c1, c2, r, c, v;
        w = 0;
        for (int l = 0; l < 2*N + 2; l++) begin
            c1 = 0; c2 = 0;
            for (int k = 0; k < N; k++) begin
                if (l < N)           begin r = l; c = k;         end
                else if (l < 2*N)    begin r = k; c = l - N;     end
                else if (l == 2*N)   begin r = k; c = k;         end
                else                 begin r = k; c = N - 1 - k; end
                v = m_cell[r*N + c];
                if (v == 1) c1++;
                else if (v == 2) c2++;
            end
            if (w == 0 && c1 == N) w = 1;
            if (w == 0 && c2 == N) w = 2;
        end
        if (w != 0) begin m_winner = w; m_over = 1; end
        else if (m_moves == NC) begin m_draw = 1; m_over = 1; end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ":board"},     bus.board,     exp_board());
        chk({tag, ":player"},    bus.player,    m_player);
        chk({tag, ":move_cnt"},  bus.move_cnt,  m_moves);
        chk({tag, ":winner"},    bus.winner,    m_winner);
        chk({tag, ":game_over"}, bus.game_over, m_over);
        chk({tag, ":draw"},      bus.draw,      m_draw);
    endtask

    // One video frame: the mark must show 2 cycles after vblank, the status 3 cycles after.
    task automatic frame(input logic [NC-1:0] press, input logic und, input string tag);
        @(negedge clk);
        bus.but_n = ~press;
`ifdef TTT_UNDO_EN
        bus.undo = und;
`endif
        undo_lvl = und;
        bus.vnotactive = 1'b1;
        model_sample(press, und);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, ":board"},     bus.board,     exp_board());
        chk({tag, ":player"},    bus.player,    m_player);
        chk({tag, ":move_cnt"},  bus.move_cnt,  m_moves);
        chk({tag, ":over_pre"},  bus.game_over, m_over);
        @(posedge clk);
        #1;
        model_check();
        chk({tag, ":winner"},    bus.winner,    m_winner);
        chk({tag, ":game_over"}, bus.game_over, m_over);
        chk({tag, ":draw"},      bus.draw,      m_draw);
        @(negedge clk);
        bus.vnotactive = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clear(input logic [NC-1:0] press, input string tag);
        @(negedge clk);
        bus.but_n = ~press;
        bus.vnotactive = 1'b0;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model_reset();
        m_prev = press;
        m_pu = undo_lvl;
        chk_all(tag);
        repeat (2) @(negedge clk);
    endtask

    logic [NC-1:0] rmask;
    logic          rund;
    int            seq [NC] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int            win_seq [5] = '{0, 3, 1, 4, 2};

    initial begin
        n_chk = 0; n_fail = 0;
        undo_lvl = 1'b0;
        rst_n = 1'b0;
        bus.vnotactive = 1'b0;
        bus.but_n = '1;
        bus.clear = 1'b0;
`ifdef TTT_UNDO_EN
        bus.undo = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        chk_all("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("reset_rel");

        frame(9'h010, 1'b0, "single_f1");
        chk("single_board", bus.board, 18'h00100);
        chk("single_player", bus.player, 1'b1);
        chk("single_cnt", bus.move_cnt, 4'd1);
        frame(9'h010, 1'b0, "single_f2");
        chk("held_board", bus.board, 18'h00100);
        chk("held_cnt", bus.move_cnt, 4'd1);

        frame(9'h000, 1'b0, "release");
        do_clear(9'h000, "clr1");
        frame(9'h101, 1'b0, "two_press");
        chk("two_board", bus.board, 18'h0);
        chk("two_player", bus.player, 1'b0);
        chk("two_cnt", bus.move_cnt, 4'd0);

        do_clear(9'h000, "clr2");
        for (int i = 0; i < 5; i++) frame(9'(1 << win_seq[i]), 1'b0, "win_seq");
        chk("win_winner", bus.winner, 2'b01);
        chk("win_over", bus.game_over, 1'b1);
        frame(9'h020, 1'b0, "after_win");
        chk("after_win_board", bus.board, 18'h00295);
        chk("after_win_cnt", bus.move_cnt, 4'd5);

        do_clear(9'h000, "clr3");
        for (int i = 0; i < NC; i++) frame(9'(1 << seq[i]), 1'b0, "draw_seq");
        chk("draw_cnt", bus.move_cnt, 4'd9);
        chk("draw_flag", bus.draw, 1'b1);
        chk("draw_winner", bus.winner, 2'b00);
        chk("draw_over", bus.game_over, 1'b1);

        do_clear(9'h000, "clr4");
        frame(9'h010, 1'b0, "occ_p0");
        frame(9'h000, 1'b0, "occ_rel");
        frame(9'h010, 1'b0, "occ_p1");
        chk("occ_board", bus.board, 18'h00100);
        chk("occ_player", bus.player, 1'b1);
        do_clear(9'h010, "clr_held");
        chk("clr_held_board", bus.board, 18'h0);
        chk("clr_held_player", bus.player, 1'b0);
        frame(9'h010, 1'b0, "clr_held_next");
        chk("clr_held_next_board", bus.board, 18'h0);
        chk("clr_held_next_cnt", bus.move_cnt, 4'd0);

        // Reset in the middle of a vblank: the held button is sampled right after release.
        @(negedge clk);
        bus.but_n = ~9'h020;
        bus.vnotactive = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all("midreset_held");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_sample(9'h020, undo_lvl);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midreset_board", bus.board, 18'h00400);
        chk("midreset_model", bus.board, exp_board());
        @(posedge clk);
        #1;
        model_check();
        chk_all("midreset_chk");
        @(negedge clk);
        bus.vnotactive = 1'b0;
        repeat (2) @(negedge clk);

`ifdef TTT_UNDO_EN
        do_clear(9'h000, "clr_u");
        frame(9'h004, 1'b0, "u_move");
        frame(9'h000, 1'b1, "u_undo");
        chk("u_board", bus.board, 18'h0);
        chk("u_cnt", bus.move_cnt, 4'd0);
        chk("u_player", bus.player, 1'b0);
        frame(9'h000, 1'b0, "u_rel");
        frame(9'h000, 1'b1, "u_undo2");
        chk("u2_board", bus.board, 18'h0);
        chk("u2_cnt", bus.move_cnt, 4'd0);
        frame(9'h004, 1'b0, "u_m1");
        frame(9'h020, 1'b0, "u_m2");
        frame(9'h000, 1'b1, "u_undo3");
        chk("u3_board", bus.board, 18'h00010);
        chk("u3_player", bus.player, 1'b1);
        frame(9'h000, 1'b0, "u_rel2");
        frame(9'h000, 1'b1, "u_undo4");
        chk("u4_board", bus.board, 18'h00010);
        chk("u4_cnt", bus.move_cnt, 4'd1);
        frame(9'h000, 1'b0, "u_rel3");
        frame(9'h080, 1'b1, "u_both");
        chk("u_both_board", bus.board, 18'h08010);
        chk("u_both_cnt", bus.move_cnt, 4'd2);
`endif

        do_clear(9'h000, "clr_rand");
        rmask = '0;
        for (int f = 0; f < 220; f++) begin
            rund = 1'b0;
`ifdef TTT_UNDO_EN
            rund = ($urandom_range(0, 3) == 0);
`endif
            case ($urandom_range(0, 4))
                0: rmask = '0;
                1, 2: rmask = 9'(1 << $urandom_range(0, NC - 1));
                3: rmask = 9'(1 << $urandom_range(0, NC - 1)) | 9'(1 << $urandom_range(0, NC - 1));
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) do_clear(rmask, "rand_clr");
            else frame(rmask, rund, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
